// File: rtl/decode_alu_dmem_if.sv
// Datapath bundle between the CPU shell (fetch/regfile/PC/writeback) and the
// decode/ALU/data-memory execute core.
interface decode_alu_dmem_if;
    logic [31:0] instruction;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_dst;
    logic        reg_wr_en;
    logic [1:0]  pc_src;
    logic [1:0]  wb_src;
    logic [15:0] imm;
    logic [27:0] j_imm;
    logic [31:0] ext_imm;
    logic [31:0] alu_out;
    logic        zero;
    logic        carryout;
    logic        overflow;
    logic [31:0] mem_rdata;

    modport master (
        output instruction, reg_a, reg_b,
        input  rs, rt, rd, reg_dst, reg_wr_en, pc_src, wb_src,
        input  imm, j_imm, ext_imm, alu_out, zero, carryout, overflow, mem_rdata
    );

    modport slave (
        input  instruction, reg_a, reg_b,
        output rs, rt, rd, reg_dst, reg_wr_en, pc_src, wb_src,
        output imm, j_imm, ext_imm, alu_out, zero, carryout, overflow, mem_rdata
    );
endinterface

// File: rtl/decode_alu_dmem.sv
// Execute core of the single-cycle MIPS subset: decoder, 32-bit ALU, word data memory.
// Optional macro DMEM_CLEAR_EN: reset also clears every data-memory word.
module decode_alu_dmem #(
    parameter int DMEM_WORDS = 1024,
    parameter int DMEM_AW    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_alu_dmem_if.slave   bus
);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_ext_imm;

    logic        w_reg_dst;
    logic        w_reg_wr_en;
    logic [1:0]  w_pc_src_dec;
    logic [1:0]  w_wb_src;
    alu_cmd_t    w_alu_cmd;
    logic        w_use_imm;
    logic        w_mem_we;
    logic        w_is_jal;
    logic        w_is_bne;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_sub;
    logic [31:0] w_b_adj;
    logic [32:0] w_sum;
    logic        w_ovf_raw;
    logic [31:0] w_alu_out;
    logic        w_carry;
    logic        w_ovf;
    logic        w_zero;

    logic [DMEM_AW-1:0] w_idx;
    logic [31:0]        r_mem [DMEM_WORDS];

    assign w_opcode = bus.instruction[31:26];
    assign w_funct  = bus.instruction[5:0];
    assign w_imm    = bus.instruction[15:0];

    // XORI is the only zero-extending immediate in this subset
    assign w_ext_imm = (w_opcode == OP_XORI) ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};

    always_comb begin
        w_reg_dst    = 1'b0;
        w_reg_wr_en  = 1'b0;
        w_pc_src_dec = 2'd0;
        w_wb_src     = 2'd0;
        w_alu_cmd    = ALU_ADD;
        w_use_imm    = 1'b0;
        w_mem_we     = 1'b0;
        w_is_jal     = 1'b0;
        w_is_bne     = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD: w_reg_wr_en = 1'b1;
                    FN_SUB: begin
                        w_reg_wr_en = 1'b1;
                        w_alu_cmd   = ALU_SUB;
                    end
                    FN_SLT: begin
                        w_reg_wr_en = 1'b1;
                        w_alu_cmd   = ALU_SLT;
                    end
                    FN_JR:   w_pc_src_dec = 2'd1;
                    default: ;
                endcase
            end
            OP_LW: begin
                w_use_imm   = 1'b1;
                w_reg_dst   = 1'b1;
                w_reg_wr_en = 1'b1;
                w_wb_src    = 2'd1;
            end
            OP_SW: begin
                w_use_imm = 1'b1;
                w_mem_we  = 1'b1;
            end
            OP_ADDI: begin
                w_use_imm   = 1'b1;
                w_reg_dst   = 1'b1;
                w_reg_wr_en = 1'b1;
            end
            OP_XORI: begin
                w_alu_cmd   = ALU_XOR;
                w_use_imm   = 1'b1;
                w_reg_dst   = 1'b1;
                w_reg_wr_en = 1'b1;
            end
            OP_J:   w_pc_src_dec = 2'd2;
            OP_JAL: begin
                w_pc_src_dec = 2'd2;
                w_reg_wr_en  = 1'b1;
                w_wb_src     = 2'd2;
                w_is_jal     = 1'b1;
            end
            OP_BNE: begin
                w_alu_cmd = ALU_SUB;
                w_is_bne  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_op_a = bus.reg_a;
    assign w_op_b = w_use_imm ? w_ext_imm : bus.reg_b;

    // SLT reuses the subtractor; sign of A-B corrected by overflow gives signed less-than
    assign w_sub     = (w_alu_cmd == ALU_SUB) || (w_alu_cmd == ALU_SLT);
    assign w_b_adj   = w_sub ? ~w_op_b : w_op_b;
    assign w_sum     = {1'b0, w_op_a} + {1'b0, w_b_adj} + {32'd0, w_sub};
    assign w_ovf_raw = (w_op_a[31] == w_b_adj[31]) && (w_sum[31] != w_op_a[31]);

    always_comb begin
        w_alu_out = 32'd0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        case (w_alu_cmd)
            ALU_ADD, ALU_SUB: begin
                w_alu_out = w_sum[31:0];
                w_carry   = w_sum[32];
                w_ovf     = w_ovf_raw;
            end
            ALU_XOR:  w_alu_out = w_op_a ^ w_op_b;
            ALU_SLT:  w_alu_out = {31'd0, w_sum[31] ^ w_ovf_raw};
            ALU_AND:  w_alu_out = w_op_a & w_op_b;
            ALU_NAND: w_alu_out = ~(w_op_a & w_op_b);
            ALU_NOR:  w_alu_out = ~(w_op_a | w_op_b);
            ALU_OR:   w_alu_out = w_op_a | w_op_b;
            default:  w_alu_out = 32'd0;
        endcase
    end

    assign w_zero = (w_alu_out == 32'd0);

    // Byte offset dropped, address bits above the memory depth wrap
    assign w_idx = w_alu_out[DMEM_AW+1:2];

`ifdef DMEM_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_mem_we) begin
            r_mem[w_idx] <= bus.reg_b;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[w_idx] <= bus.reg_b;
        end
    end
`endif

    assign bus.mem_rdata = rst_n ? r_mem[w_idx] : 32'd0;

    assign bus.rs        = bus.instruction[25:21];
    assign bus.rt        = bus.instruction[20:16];
    assign bus.rd        = w_is_jal ? 5'd31 : bus.instruction[15:11];
    assign bus.reg_dst   = w_reg_dst;
    assign bus.reg_wr_en = w_reg_wr_en;
    assign bus.pc_src    = w_is_bne ? (w_zero ? 2'd0 : 2'd3) : w_pc_src_dec;
    assign bus.wb_src    = w_wb_src;
    assign bus.imm       = w_imm;
    assign bus.j_imm     = {bus.instruction[25:0], 2'b00};
    assign bus.ext_imm   = w_ext_imm;
    assign bus.alu_out   = w_alu_out;
    assign bus.zero      = w_zero;
    assign bus.carryout  = w_carry;
    assign bus.overflow  = w_ovf;

endmodule

// File: tb/tb_decode_alu_dmem.sv
// Directed-vector bench for decode_alu_dmem: decode/ALU table plus memory and reset sequences.
module tb_decode_alu_dmem;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    decode_alu_dmem_if bus ();

    decode_alu_dmem #(
        .DMEM_WORDS (1024),
        .DMEM_AW    (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        bit          chk_alu;
        logic [31:0] alu;
        logic        z;
        logic        co;
        logic        ov;
        logic        wr;
        logic        dst;
        logic [1:0]  pc;
        logic [1:0]  wb;
        logic [31:0] ext;
        logic [4:0]  rd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.instruction = ins;
        bus.reg_a       = a;
        bus.reg_b       = b;
    endtask

    logic [31:0] exp_after_rst;

    initial begin
        checks = 0;
        errors = 0;
        //              name         instr         a             b             chk alu           z     co    ov    wr    dst   pc    wb    ext           rd
        vecs[0]  = '{"add_ovf",    32'h00221820, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 32'h00001820, 5'd3};
        vecs[1]  = '{"sub_neg",    32'h00221822, 32'hFFFFFFFF, 32'h00000001, 1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h00001822, 5'd3};
        vecs[2]  = '{"slt_neg",    32'h0022182A, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0000182A, 5'd3};
        vecs[3]  = '{"slt_ovf_lt", 32'h0022182A, 32'h80000000, 32'h00000001, 1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0000182A, 5'd3};
        vecs[4]  = '{"slt_ovf_ge", 32'h0022182A, 32'h7FFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0000182A, 5'd3};
        vecs[5]  = '{"sub_eq",     32'h00221822, 32'h00000005, 32'h00000005, 1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h00001822, 5'd3};
        vecs[6]  = '{"add_carry",  32'h00221820, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h00001820, 5'd3};
        vecs[7]  = '{"xori",       32'h38228001, 32'h0000FFFF, 32'h12345678, 1, 32'h00007FFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h00008001, 5'd16};
        vecs[8]  = '{"addi_m1",    32'h2022FFFF, 32'h00000005, 32'h00000000, 1, 32'h00000004, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'hFFFFFFFF, 5'd31};
        vecs[9]  = '{"addi_ovf",   32'h20228000, 32'h80000000, 32'h00000000, 1, 32'h7FFF8000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'hFFFF8000, 5'd16};
        vecs[10] = '{"bne_eq",     32'h14220010, 32'h00000003, 32'h00000003, 1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h00000010, 5'd0};
        vecs[11] = '{"bne_ne",     32'h14220010, 32'h00000003, 32'h00000004, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 32'h00000010, 5'd0};
        vecs[12] = '{"j",          32'h08000010, 32'h00000000, 32'h00000000, 0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 32'h00000010, 5'd0};
        vecs[13] = '{"jal",        32'h0C000040, 32'h00000000, 32'h00000000, 0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, 32'h00000040, 5'd31};
        vecs[14] = '{"jr",         32'h00200008, 32'h00000400, 32'h00000000, 0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 32'h00000008, 5'd0};
        vecs[15] = '{"nop_op3f",   32'hFC221234, 32'h00000001, 32'h00000002, 0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h00001234, 5'd2};
        vecs[16] = '{"nop_funct",  32'h00221824, 32'h00000001, 32'h00000002, 0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h00001824, 5'd3};

        // Reset: combinational outputs live, memory read forced to 0
        rst_n = 1'b0;
        drive(32'h8C220004, 32'h00000100, 32'h0);
        #2;
        chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
        chk("rst_alu_out", bus.alu_out, 32'h00000104);
        chk("rst_wb_src", {30'd0, bus.wb_src}, 32'd1);
        $display("txn reset lw alu_out=%h mem_rdata=%h", bus.alu_out, bus.mem_rdata);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DMEM_CLEAR_EN
        #1;
        chk("clr_after_rst", bus.mem_rdata, 32'h0);
`endif

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].a, vecs[i].b);
            #1;
            if (vecs[i].chk_alu) begin
                chk({vecs[i].name, ".alu_out"},  bus.alu_out, vecs[i].alu);
                chk({vecs[i].name, ".zero"},     {31'd0, bus.zero}, {31'd0, vecs[i].z});
                chk({vecs[i].name, ".carryout"}, {31'd0, bus.carryout}, {31'd0, vecs[i].co});
                chk({vecs[i].name, ".overflow"}, {31'd0, bus.overflow}, {31'd0, vecs[i].ov});
            end
            chk({vecs[i].name, ".reg_wr_en"}, {31'd0, bus.reg_wr_en}, {31'd0, vecs[i].wr});
            if (vecs[i].wr)
                chk({vecs[i].name, ".reg_dst"}, {31'd0, bus.reg_dst}, {31'd0, vecs[i].dst});
            chk({vecs[i].name, ".pc_src"},  {30'd0, bus.pc_src}, {30'd0, vecs[i].pc});
            chk({vecs[i].name, ".wb_src"},  {30'd0, bus.wb_src}, {30'd0, vecs[i].wb});
            chk({vecs[i].name, ".ext_imm"}, bus.ext_imm, vecs[i].ext);
            chk({vecs[i].name, ".rd"},      {27'd0, bus.rd}, {27'd0, vecs[i].rd});
            chk({vecs[i].name, ".rs"},      {27'd0, bus.rs}, {27'd0, vecs[i].instr[25:21]});
            chk({vecs[i].name, ".rt"},      {27'd0, bus.rt}, {27'd0, vecs[i].instr[20:16]});
            chk({vecs[i].name, ".imm"},     {16'd0, bus.imm}, {16'd0, vecs[i].instr[15:0]});
            chk({vecs[i].name, ".j_imm"},   {4'd0, bus.j_imm}, {4'd0, vecs[i].instr[25:0], 2'b00});
            $display("txn %0d %s instr=%h a=%h b=%h alu_out=%h pc_src=%0d", i, vecs[i].name,
                     vecs[i].instr, vecs[i].a, vecs[i].b, bus.alu_out, bus.pc_src);
        end

        // SW then SW to same word: old data visible until the edge
        @(negedge clk);
        drive(32'hAC220004, 32'h00000100, 32'h11111111);
        #1;
        chk("sw1.reg_wr_en", {31'd0, bus.reg_wr_en}, 32'd0);
        chk("sw1.alu_out", bus.alu_out, 32'h00000104);
        @(posedge clk);
        #1;
        chk("sw1.after_edge", bus.mem_rdata, 32'h11111111);
        $display("txn sw addr=%h data=11111111 rdata=%h", bus.alu_out, bus.mem_rdata);

        @(negedge clk);
        drive(32'hAC220004, 32'h00000100, 32'hDEADBEEF);
        #1;
        chk("sw2.before_edge", bus.mem_rdata, 32'h11111111);
        @(posedge clk);
        #1;
        chk("sw2.after_edge", bus.mem_rdata, 32'hDEADBEEF);
        $display("txn sw addr=%h data=DEADBEEF rdata=%h", bus.alu_out, bus.mem_rdata);

        @(negedge clk);
        drive(32'h8C220004, 32'h00000100, 32'h0);
        #1;
        chk("lw.mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
        chk("lw.wb_src", {30'd0, bus.wb_src}, 32'd1);
        chk("lw.reg_dst", {31'd0, bus.reg_dst}, 32'd1);
        chk("lw.reg_wr_en", {31'd0, bus.reg_wr_en}, 32'd1);
        $display("txn lw addr=%h rdata=%h", bus.alu_out, bus.mem_rdata);

        // Byte offset ignored, high address bits wrap
        @(negedge clk);
        drive(32'h8C220000, 32'h00000107, 32'h0);
        #1;
        chk("lw_byteoff.mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
        $display("txn lw addr=%h rdata=%h", bus.alu_out, bus.mem_rdata);
        @(negedge clk);
        drive(32'h8C220004, 32'h00001100, 32'h0);
        #1;
        chk("lw_wrap.mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
        $display("txn lw addr=%h rdata=%h", bus.alu_out, bus.mem_rdata);

        // Reset pulled low in the middle of an SW cycle
        @(negedge clk);
        drive(32'hAC220004, 32'h00000100, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sw_rst.mem_rdata", bus.mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("sw_rst.after_edge", bus.mem_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h8C220004, 32'h00000100, 32'h0);
        #1;
`ifdef DMEM_CLEAR_EN
        exp_after_rst = 32'h0;
`else
        exp_after_rst = 32'hDEADBEEF;
`endif
        chk("sw_rst.lw_after", bus.mem_rdata, exp_after_rst);
        $display("txn lw after reset addr=%h rdata=%h", bus.alu_out, bus.mem_rdata);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
